wordle_letter_entry: RTL and testbench

WORDLE_LETTER_ENTRY -- requirements
Module: wordle_letter_entry

---
 rtl/wordle_letter_entry.sv | 149 ++++++++++++++
 tb/tb_wordle_letter_entry.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wordle_letter_entry.sv
// Wordle guess entry: builds a five-letter guess from button pulses and
// streams it out one letter per valid/ready transfer.
//
// Ports:
//   Clk, reset_n            clock, asynchronous active-low reset
//   BtnU, BtnD              next / previous letter (one-cycle pulses)
//   BtnC                    commit letter, submit guess, or restart
//   BtnL                    delete last letter
//   game_over               level from game FSM, forces LOCK
//   out_ready               consumer accepts out_letter this cycle
//   out_valid/letter/last   guess letter stream, last marks fifth letter
//   cursor_letter           letter currently selected for entry
//   pos                     letters buffered (0..5)
//   buf_flat                slot 0 in [39:32] .. slot 4 in [7:0]
//   guess_count             completed guesses sent (0..6)

module wordle_letter_entry (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        BtnU,
    input  logic        BtnD,
    input  logic        BtnC,
    input  logic        BtnL,
    input  logic        game_over,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_letter,
    output logic        out_last,
    output logic [7:0]  cursor_letter,
    output logic [2:0]  pos,
    output logic [39:0] buf_flat,
    output logic [2:0]  guess_count
);

    localparam logic [7:0] LTR_A = 8'h41;
    localparam logic [7:0] LTR_Z = 8'h5A;

    typedef enum logic [1:0] {
        EDIT = 2'd0,
        SEND = 2'd1,
        LOCK = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cursor_q, cursor_d;
    logic [2:0]  pos_q, pos_d;
    logic [2:0]  gcnt_q, gcnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  slot_q [5];
    logic [7:0]  slot_d [5];

    logic        step_up;
    logic        step_dn;
    logic [7:0]  cursor_inc;
    logic [7:0]  cursor_dec;

    // Simultaneous up/down cancel out.
    assign step_up    = BtnU & ~BtnD;
    assign step_dn    = BtnD & ~BtnU;
    assign cursor_inc = (cursor_q == LTR_Z) ? LTR_A : cursor_q + 8'd1;
    assign cursor_dec = (cursor_q == LTR_A) ? LTR_Z : cursor_q - 8'd1;

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        pos_d    = pos_q;
        gcnt_d   = gcnt_q;
        idx_d    = idx_q;
        for (int i = 0; i < 5; i++) slot_d[i] = slot_q[i];

        case (state_q)
            EDIT: begin
                if (game_over) begin
                    state_d = LOCK;
                end else if (BtnC && pos_q < 3'd5) begin
                    // Commit stores the pre-edge cursor; U/D are overridden.
                    slot_d[pos_q] = cursor_q;
                    pos_d         = pos_q + 3'd1;
                    cursor_d      = LTR_A;
                end else begin
                    if (step_up) cursor_d = cursor_inc;
                    else if (step_dn) cursor_d = cursor_dec;
                    if (BtnC) begin
                        state_d = SEND;
                        idx_d   = 3'd0;
                    end else if (BtnL && pos_q != 3'd0) begin
                        pos_d         = pos_q - 3'd1;
                        slot_d[pos_d] = 8'h00;
                    end
                end
            end
            SEND: begin
                if (game_over) begin
                    state_d = LOCK;
                    idx_d   = 3'd0;
                end else if (out_ready) begin
                    if (idx_q == 3'd4) begin
                        for (int i = 0; i < 5; i++) slot_d[i] = 8'h00;
                        pos_d   = 3'd0;
                        idx_d   = 3'd0;
                        gcnt_d  = gcnt_q + 3'd1;
                        state_d = (gcnt_q == 3'd5) ? LOCK : EDIT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            LOCK: begin
                if (BtnC && !game_over) begin
                    for (int i = 0; i < 5; i++) slot_d[i] = 8'h00;
                    pos_d    = 3'd0;
                    gcnt_d   = 3'd0;
                    cursor_d = LTR_A;
                    state_d  = EDIT;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= EDIT;
            cursor_q <= LTR_A;
            pos_q    <= 3'd0;
            gcnt_q   <= 3'd0;
            idx_q    <= 3'd0;
            for (int i = 0; i < 5; i++) slot_q[i] <= 8'h00;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            pos_q    <= pos_d;
            gcnt_q   <= gcnt_d;
            idx_q    <= idx_d;
            for (int i = 0; i < 5; i++) slot_q[i] <= slot_d[i];
        end
    end

    // Outputs decode straight from state so reset drops out_valid at once.
    assign out_valid     = (state_q == SEND);
    assign out_letter    = out_valid ? slot_q[idx_q] : 8'h00;
    assign out_last      = out_valid && (idx_q == 3'd4);
    assign cursor_letter = cursor_q;
    assign pos           = pos_q;
    assign guess_count   = gcnt_q;
    assign buf_flat      = {slot_q[0], slot_q[1], slot_q[2],
                            slot_q[3], slot_q[4]};

endmodule

// File: tb/tb_wordle_letter_entry.sv
// Scoreboarded bench for wordle_letter_entry: directed scenarios
// followed by randomized button / ready / game_over traffic.

module tb_wordle_letter_entry;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        BtnU = 1'b0, BtnD = 1'b0, BtnC = 1'b0, BtnL = 1'b0;
    logic        game_over = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_letter;
    logic        out_last;
    logic [7:0]  cursor_letter;
    logic [2:0]  pos;
    logic [39:0] buf_flat;
    logic [2:0]  guess_count;

    wordle_letter_entry dut (
        .Clk(Clk), .reset_n(reset_n),
        .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC), .BtnL(BtnL),
        .game_over(game_over), .out_ready(out_ready),
        .out_valid(out_valid), .out_letter(out_letter),
        .out_last(out_last), .cursor_letter(cursor_letter),
        .pos(pos), .buf_flat(buf_flat), .guess_count(guess_count)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [7:0] letter;
        logic       last;
    } xfer_t;
    xfer_t exp_q[$];

    // Reference model: 0=edit 1=send 2=lock; cursor as 0..25.
    int         m_st = 0;
    int         m_cur = 0;
    int         m_idx = 0;
    int         m_gc = 0;
    logic [7:0] m_buf[$];

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic logic [39:0] m_flat();
        logic [39:0] f = '0;
        for (int i = 0; i < 5; i++)
            f = {f[31:0], (i < m_buf.size()) ? m_buf[i] : 8'h00};
        return f;
    endfunction

    function automatic void m_reset();
        m_st = 0; m_cur = 0; m_idx = 0; m_gc = 0;
        m_buf.delete();
    endfunction

    function automatic void check_state();
        logic [7:0] ltr;
        ltr = (m_st == 1) ? m_buf[m_idx] : 8'h00;
        chk("cursor", cursor_letter, 64'(65 + m_cur));
        chk("pos", pos, m_buf.size());
        chk("buf_flat", buf_flat, m_flat());
        chk("guess_count", guess_count, m_gc);
        chk("out_valid", out_valid, m_st == 1);
        chk("out_letter", out_letter, ltr);
        chk("out_last", out_last, m_st == 1 && m_idx == 4);
    endfunction

    function automatic void model_update(bit u, bit d, bit c, bit l,
                                         bit go, bit rdy);
        int mv;
        mv = (u && !d) ? 1 : ((d && !u) ? 25 : 0);
        case (m_st)
            0: begin
                if (go) m_st = 2;
                else if (c && m_buf.size() < 5) begin
                    m_buf.push_back(8'(65 + m_cur));
                    m_cur = 0;
                end else begin
                    m_cur = (m_cur + mv) % 26;
                    if (c) begin
                        m_st = 1; m_idx = 0;
                    end else if (l && m_buf.size() > 0)
                        void'(m_buf.pop_back());
                end
            end
            1: begin
                if (go) begin
                    m_st = 2; m_idx = 0;
                end else if (rdy) begin
                    m_idx++;
                    if (m_idx == 5) begin
                        m_buf.delete();
                        m_idx = 0;
                        m_gc++;
                        m_st = (m_gc == 6) ? 2 : 0;
                    end
                end
            end
            default: begin
                if (c && !go) begin
                    m_buf.delete();
                    m_gc = 0; m_cur = 0; m_st = 0;
                end
            end
        endcase
    endfunction

    // One cycle: check, drive at negedge, predict, clock, return at negedge.
    task automatic step(bit u, bit d, bit c, bit l, bit go, bit rdy);
        if (go) rdy = 1'b0;
        check_state();
        BtnU = u; BtnD = d; BtnC = c; BtnL = l;
        game_over = go; out_ready = rdy;
        if (m_st == 1 && rdy)
            exp_q.push_back({m_buf[m_idx], 1'(m_idx == 4)});
        @(posedge Clk);
        model_update(u, d, c, l, go, rdy);
        @(negedge Clk);
    endtask

    task automatic enter(int k);
        for (int i = 0; i < k; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 5; i++) enter($urandom_range(0, 25));
    endtask

    task automatic drain();
        int guard = 0;
        while (m_st == 1 && guard < 60) begin
            step(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("drain_bound", m_st == 1, 0);
    endtask

    task automatic async_reset();
        BtnU = 0; BtnD = 0; BtnC = 0; BtnL = 0;
        game_over = 0; out_ready = 0;
        #3 reset_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_letter", out_letter, 0);
        chk("rst_pos", pos, 0);
        chk("rst_buf", buf_flat, 0);
        chk("rst_cursor", cursor_letter, 8'h41);
        @(negedge Clk);
        reset_n = 1'b1;
        m_reset();
        exp_q.delete();
    endtask

    // Monitor: every accepted transfer must match the next expectation.
    initial begin
        xfer_t e;
        forever begin
            @(negedge Clk);
            #2;
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL xfer_unexpected: got %0h expected none",
                             out_letter);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_letter", out_letter, e.letter);
                    chk("xfer_last", out_last, e.last);
                end
            end
        end
    end

    initial begin
        bit [6:0] rdy_pat;
        logic [7:0] cur_save;
        rdy_pat = 7'b1011011;
        m_reset();
        repeat (2) @(negedge Clk);
        reset_n = 1'b1;

        // Cursor wrap both ways.
        step(0, 1, 0, 0, 0, 0);
        chk("wrap_dn", cursor_letter, 8'h5A);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap_up", cursor_letter, 8'h41);
        step(1, 1, 0, 0, 0, 0);
        chk("ud_both", cursor_letter, 8'h41);

        // RENEW then a stalled send.
        enter(17); enter(4); enter(13); enter(4); enter(22);
        chk("renew_flat", buf_flat, 40'h52454E4557);
        chk("renew_pos", pos, 5);
        step(0, 0, 1, 0, 0, 0);
        chk("send_valid", out_valid, 1);
        chk("send_first", out_letter, 8'h52);
        for (int i = 6; i >= 0; i--) step(0, 0, 0, 0, 0, rdy_pat[i]);
        chk("renew_gc", guess_count, 1);
        chk("renew_pos0", pos, 0);
        chk("renew_done", out_valid, 0);

        // Delete and commit/delete priority.
        enter(0); enter(1); enter(2);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("del_pos", pos, 1);
        chk("del_buf", buf_flat, {8'h41, 32'h0});
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("del_empty", pos, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        chk("cl_pos", pos, 1);
        chk("cl_buf", buf_flat, {8'h43, 32'h0});

        // Reset mid-send.
        for (int i = 0; i < 4; i++) enter($urandom_range(0, 25));
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        async_reset();

        // Six guesses lock the game; restart with BtnC.
        for (int g = 0; g < 6; g++) begin
            fill_random();
            step(0, 0, 1, 0, 0, 0);
            drain();
        end
        chk("lock_gc", guess_count, 6);
        cur_save = cursor_letter;
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        chk("lock_cursor", cursor_letter, cur_save);
        chk("lock_valid", out_valid, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("restart_gc", guess_count, 0);
        chk("restart_cur", cursor_letter, 8'h41);

        // game_over during send after two transfers.
        fill_random();
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("go_valid", out_valid, 0);
        step(0, 0, 1, 0, 1, 0);
        cur_save = cursor_letter;
        step(1, 0, 0, 0, 0, 0);
        chk("go_locked", cursor_letter, cur_save);
        step(0, 0, 1, 0, 0, 0);
        chk("go_restart", pos, 0);

        // Random traffic.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 60) == 0, $urandom_range(0, 1) == 1);

        step(0, 0, 0, 0, 0, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
